// File: rtl/gemm_pkg.sv
// Shared types and default constants for the GEMM command controller.
package gemm_pkg;

    localparam int GEMM_DW         = 32;
    localparam int DEPTH_DEF       = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int ACK_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } gemm_state_e;

    typedef struct packed {
        logic [GEMM_DW-1:0] op1;
        logic [GEMM_DW-1:0] op2;
    } gemm_cmd_t;

endpackage

// File: rtl/gemm_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO; extra pointer MSB tells full from empty.
module gemm_cmd_fifo
    import gemm_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  gemm_cmd_t              wdata,
    output gemm_cmd_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    gemm_cmd_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/gemm_cmd_ctrl.sv
// GEMM command controller: queues core-issued commands and sequences the accelerator start/done handshake.
// Optional acknowledge timeout enabled by defining GEMM_ACK_TIMEOUT_EN.
module gemm_cmd_ctrl
    import gemm_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int DW          = GEMM_DW,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gemm_valid,
    input  logic [DW-1:0]    gemm_rdata1,
    input  logic [DW-1:0]    gemm_rdata2,
    output logic             cmd_stall,
    input  logic             gemm_done,
    output logic             acc_start,
    output logic [DW-1:0]    acc_op1,
    output logic [DW-1:0]    acc_op2,
    output logic             busy,
    output logic             irq,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DW != GEMM_DW || ACK_TIMEOUT < 1) begin : g_bad_cfg
        $error("gemm_cmd_ctrl: unsupported parameter set");
    end

    gemm_state_e            state;
    gemm_cmd_t              cmd_in;
    gemm_cmd_t              head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   pop;

    assign cmd_in.op1 = gemm_rdata1;
    assign cmd_in.op2 = gemm_rdata2;

    // The head is taken only when the accelerator reports idle, so an externally busy engine holds the queue.
    assign pop       = (state == IDLE) && !empty && gemm_done;
    assign cmd_stall = full;
    assign busy      = (count != '0) || (state != IDLE);

    gemm_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gemm_valid),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef GEMM_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] ack_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_start <= 1'b0;
            acc_op1   <= '0;
            acc_op2   <= '0;
            irq       <= 1'b0;
            done_cnt  <= '0;
`ifdef GEMM_ACK_TIMEOUT_EN
            ack_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            acc_start <= 1'b0;
            irq       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        acc_op1 <= head.op1;
                        acc_op2 <= head.op2;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    acc_start <= 1'b1;
                    state     <= WAIT_ACK;
`ifdef GEMM_ACK_TIMEOUT_EN
                    ack_cnt   <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (!gemm_done) begin
                        state <= WAIT_DONE;
`ifdef GEMM_ACK_TIMEOUT_EN
                    end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        // Abandon a job the accelerator never acknowledged; it is not counted.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (gemm_done) begin
                        irq      <= 1'b1;
                        done_cnt <= done_cnt + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_cmd_ctrl.sv
// Directed scoreboard bench for gemm_cmd_ctrl (DEPTH=4, CNT_W=4, ACK_TIMEOUT=8).
module tb_gemm_cmd_ctrl;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             gemm_valid = 1'b0;
    logic [DW-1:0]    gemm_rdata1 = '0;
    logic [DW-1:0]    gemm_rdata2 = '0;
    logic             gemm_done = 1'b1;
    logic             cmd_stall;
    logic             acc_start;
    logic [DW-1:0]    acc_op1;
    logic [DW-1:0]    acc_op2;
    logic             busy;
    logic             irq;
    logic [CNT_W-1:0] done_cnt;
    logic             err;

    int          total = 0;
    int          bad = 0;
    int          start_cnt = 0;
    int          irq_cnt = 0;
    int          exp_start = 0;
    int          exp_irq = 0;
    bit          model_en = 1'b0;
    logic [63:0] sb [$];

    gemm_cmd_ctrl #(
        .DEPTH       (4),
        .DW          (DW),
        .CNT_W       (CNT_W),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gemm_valid  (gemm_valid),
        .gemm_rdata1 (gemm_rdata1),
        .gemm_rdata2 (gemm_rdata2),
        .cmd_stall   (cmd_stall),
        .gemm_done   (gemm_done),
        .acc_start   (acc_start),
        .acc_op1     (acc_op1),
        .acc_op2     (acc_op2),
        .busy        (busy),
        .irq         (irq),
        .done_cnt    (done_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one command for one cycle, starting on a falling edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit accept);
        gemm_valid  = 1'b1;
        gemm_rdata1 = a;
        gemm_rdata2 = b;
        if (accept) sb.push_back({a, b});
        @(negedge clk);
        gemm_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic wait_start(input int max_cyc);
        int n = 0;
        while (acc_start !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", acc_start, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Start/irq monitor: each start must match the oldest accepted command.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (acc_start === 1'b1) begin
                start_cnt++;
                chk("sb_has_entry_at_start", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("acc_op1", acc_op1, e[63:32]);
                    chk("acc_op2", acc_op2, e[31:0]);
                end
            end
            if (irq === 1'b1) irq_cnt++;
        end
    end

    // Accelerator model: drops done one cycle after start, raises it five cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && acc_start === 1'b1) begin
                @(negedge clk);
                gemm_done = 1'b0;
                repeat (5) @(negedge clk);
                gemm_done = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst_stall", cmd_stall, 0);
        chk("rst_start", acc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cnt", done_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_op1", acc_op1, 0);

        // Single job with latency check
        model_en = 1'b1;
        send(32'h100, 32'h200, 1'b1);
        @(negedge clk);
        chk("t1_no_early_start", acc_start, 0);
        @(negedge clk);
        chk("t1_start_latency", acc_start, 1);
        wait_idle(40);
        exp_start += 1;
        exp_irq   += 1;
        chk("t1_starts", start_cnt, exp_start);
        chk("t1_irqs", irq_cnt, exp_irq);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_op1_held", acc_op1, 32'h100);

        // Full queue with accelerator held busy
        model_en  = 1'b0;
        gemm_done = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("t2_stall_before_push", cmd_stall, (i == 5));
            send(i, 32'h1000 + i, (i <= 4));
        end
        chk("t2_stall_full", cmd_stall, 1);
        chk("t2_busy", busy, 1);
        chk("t2_no_start_while_busy", start_cnt, exp_start);
        gemm_done = 1'b1;
        model_en  = 1'b1;
        wait_idle(200);
        exp_start += 4;
        exp_irq   += 4;
        chk("t2_starts", start_cnt, exp_start);
        chk("t2_irqs", irq_cnt, exp_irq);
        chk("t2_done_cnt", done_cnt, 5);
        chk("t2_sb_empty", sb.size(), 0);

        // Push against a full FIFO in the same cycle as a pop, then retry
        model_en  = 1'b0;
        gemm_done = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'h30 + i, 32'h300 + i, 1'b1);
        chk("t3_full", cmd_stall, 1);
        gemm_done   = 1'b1;
        model_en    = 1'b1;
        gemm_valid  = 1'b1;
        gemm_rdata1 = 32'h35;
        gemm_rdata2 = 32'h305;
        @(negedge clk);
        chk("t3_stall_released", cmd_stall, 0);
        sb.push_back({32'h35, 32'h305});
        @(negedge clk);
        gemm_valid = 1'b0;
        wait_idle(200);
        exp_start += 5;
        exp_irq   += 5;
        chk("t3_starts", start_cnt, exp_start);
        chk("t3_irqs", irq_cnt, exp_irq);
        chk("t3_done_cnt", done_cnt, 10);
        chk("t3_sb_empty", sb.size(), 0);

        // Reset during WAIT_DONE with a second command still queued
        model_en = 1'b0;
        send(32'hA1, 32'hA2, 1'b1);
        send(32'hB1, 32'hB2, 1'b1);
        wait_start(20);
        exp_start += 1;
        gemm_done = 1'b0;
        @(negedge clk);
        chk("t4_busy_in_job", busy, 1);
        do_reset();
        gemm_done = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_starts", start_cnt, exp_start);
        chk("t4_irqs", irq_cnt, exp_irq);
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_busy", busy, 0);
        chk("t4_stall", cmd_stall, 0);
        chk("t4_op1", acc_op1, 0);
        chk("t4_op2", acc_op2, 0);
        chk("t4_start_low", acc_start, 0);

`ifdef GEMM_ACK_TIMEOUT_EN
        // Accelerator never acknowledges: sticky err after 8 cycles in WAIT_ACK
        send(32'hC1, 32'hC2, 1'b1);
        wait_start(20);
        exp_start += 1;
        repeat (7) @(negedge clk);
        chk("t5_err_not_yet", err, 0);
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_cnt_unchanged", done_cnt, 0);
        chk("t5_no_irq", irq_cnt, exp_irq);
        model_en = 1'b1;
        send(32'hD1, 32'hD2, 1'b1);
        wait_idle(60);
        exp_start += 1;
        exp_irq   += 1;
        chk("t5_next_done", done_cnt, 1);
        chk("t5_err_sticky", err, 1);
        chk("t5_starts", start_cnt, exp_start);
`else
        chk("t5_err_tied_low", err, 0);
`endif

        // Completion counter wraps at 2^CNT_W
        do_reset();
        model_en  = 1'b1;
        gemm_done = 1'b1;
        for (int j = 0; j < 17; j++) begin
            send(j, 32'hF000 + j, 1'b1);
            wait_idle(60);
        end
        exp_start += 17;
        exp_irq   += 17;
        chk("t6_wrap_cnt", done_cnt, 1);
        chk("t6_starts", start_cnt, exp_start);
        chk("t6_irqs", irq_cnt, exp_irq);
        chk("t6_err_clear", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
